// File: rtl/dot_accum_ctrl.sv
// Job sequencer for a pipelined adder tree: gates beats in, tracks
// in-flight beats through the tree latency, accumulates per-beat sums.
module dot_accum_ctrl #(
  parameter int SIZE  = 8,
  parameter int NUM   = 256,
  parameter int LEN_W = 16,
  parameter int ACC_W = 48
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [LEN_W-1:0]             cfg_chunks,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NUM)+SIZE-1:0]  tree_sum,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ACC_W-1:0]             res_data,
  output logic                         res_ovf,
  output logic                         busy
);

  localparam int LAT = $clog2(NUM);
  localparam int TSW = LAT + SIZE;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] recvd;
  logic [LEN_W-1:0] recvd_n;
  logic [LAT-1:0]   vld_pipe;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             ret;
  logic             cfg_fire;

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == FEED);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_data  = acc;
  assign res_ovf   = ovf;

  assign accept   = in_valid & in_ready;
  assign cfg_fire = cfg_valid & cfg_ready;
  assign ret      = vld_pipe[LAT-1];

  assign sum = {1'b0, acc}
             + {{(ACC_W+1-TSW){1'b0}}, tree_sum};

  // FSM looks at the count including this cycle's return
  assign recvd_n = recvd + LEN_W'(ret);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cfg_fire) begin
          if (cfg_chunks == '0) state_n = DONE;
          else                  state_n = FEED;
        end
      end
      FEED: begin
        if (accept && (issued + LEN_W'(1)) == len)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (recvd_n == len) state_n = DONE;
      end
      DONE: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | LAT'(accept);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len    <= '0;
      issued <= '0;
      recvd  <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else if (cfg_fire) begin
      len    <= cfg_chunks;
      issued <= '0;
      recvd  <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) issued <= issued + LEN_W'(1);
      if (ret) begin
        acc   <= sum[ACC_W-1:0];
        ovf   <= ovf | sum[ACC_W];
        recvd <= recvd_n;
      end
    end
  end

endmodule

// File: tb/tb_dot_accum_ctrl.sv
// Bench for dot_accum_ctrl: behavioural tree delay lines, job table,
// result scoreboard, overflow and mid-job reset sequences.
module tb_dot_accum_ctrl;

  localparam int LAT_A = 8;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_valid = 0, cfg_ready;
  logic [15:0] cfg_chunks = 0;
  logic        in_valid = 0, in_ready;
  logic [15:0] tree_sum;
  logic        res_valid, res_ready = 0;
  logic [47:0] res_data;
  logic        res_ovf, busy;

  logic        b_cfg_valid = 0, b_cfg_ready;
  logic [15:0] b_cfg_chunks = 0;
  logic        b_in_valid = 0, b_in_ready;
  logic [9:0]  b_tree_sum;
  logic        b_res_valid, b_res_ready = 0;
  logic [9:0]  b_res_data;
  logic        b_res_ovf, b_busy;

  int lane_a = 0;
  int lane_b = 0;
  int checks = 0;
  int failures = 0;

  dot_accum_ctrl u_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chunks(cfg_chunks),
    .in_valid(in_valid), .in_ready(in_ready),
    .tree_sum(tree_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf),
    .busy(busy)
  );

  dot_accum_ctrl #(
    .SIZE(8), .NUM(4), .LEN_W(16), .ACC_W(10)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
    .cfg_chunks(b_cfg_chunks),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .tree_sum(b_tree_sum),
    .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_data(b_res_data), .res_ovf(b_res_ovf),
    .busy(b_busy)
  );

  // free-running trees: uniform lanes, garbage when no beat offered
  logic [15:0] tp_a [LAT_A];
  logic [9:0]  tp_b [LAT_B];
  assign tree_sum   = tp_a[LAT_A-1];
  assign b_tree_sum = tp_b[LAT_B-1];

  always @(posedge clk) begin
    tp_a[0] <= in_valid ? 16'(lane_a * 256) : 16'($urandom);
    for (int i = 1; i < LAT_A; i++) tp_a[i] <= tp_a[i-1];
    tp_b[0] <= b_in_valid ? 10'(lane_b * 4) : 10'($urandom);
    for (int i = 1; i < LAT_B; i++) tp_b[i] <= tp_b[i-1];
  end

  typedef struct {
    int          chunks;
    int          lane;
    logic [15:0] pat;
    int          plen;
    int          hold;
    logic [47:0] data;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [47:0] d;
    logic        o;
  } res_t;

  vec_t vecs[6];
  res_t sb[$];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic run_job(vec_t v);
    int issued;
    int idx;
    int k;
    logic [47:0] hd;
    logic ho;
    res_t e;
    @(negedge clk);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid  = 1;
    cfg_chunks = 16'(v.chunks);
    lane_a     = v.lane;
    sb.push_back('{v.data, v.ovf});
    @(negedge clk);
    cfg_valid = 0;
    chk("busy", busy, 1);
    if (v.chunks == 0) begin
      chk("zero_res_valid", res_valid, 1);
      chk("zero_in_ready", in_ready, 0);
    end else begin
      issued = 0;
      idx = 0;
      chk("in_ready_feed", in_ready, 1);
      while (issued < v.chunks && idx < 200) begin
        in_valid = (idx < v.plen) ? v.pat[idx] : 1'b1;
        if (in_valid) issued++;
        idx++;
        @(negedge clk);
      end
      in_valid = 1;
      chk("in_ready_drop", in_ready, 0);
      k = 1;
      while (!res_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
      in_valid = 0;
      chk("latency", k, LAT_A + 1);
    end
    hd = res_data;
    ho = res_ovf;
    for (int h = 0; h < v.hold; h++) begin
      cfg_valid = 1;
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, hd);
      chk("hold_ovf", res_ovf, ho);
      chk("hold_cfg_ready", cfg_ready, 0);
    end
    cfg_valid = 0;
    chk("res_valid", res_valid, 1);
    e = sb.pop_front();
    chk("res_data", res_data, e.d);
    chk("res_ovf", res_ovf, e.o);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("res_valid_clr", res_valid, 0);
    chk("cfg_ready_back", cfg_ready, 1);
    chk("busy_clr", busy, 0);
  endtask

  task automatic wait_b(string name);
    int k;
    k = 0;
    while (!b_res_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk(name, b_res_valid, 1);
  endtask

  initial begin
    vecs[0] = '{1, 255, 16'h0001, 1, 0, 48'd65280, 1'b0};
    vecs[1] = '{3, 1, 16'h0007, 3, 0, 48'd768, 1'b0};
    vecs[2] = '{4, 2, 16'h0059, 7, 0, 48'd2048, 1'b0};
    vecs[3] = '{2, 3, 16'h0003, 2, 5, 48'd1536, 1'b0};
    vecs[4] = '{0, 0, 16'h0000, 0, 0, 48'd0, 1'b0};
    vecs[5] = '{5, 255, 16'h0155, 9, 2, 48'd326400, 1'b0};

    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // overflow in a 10-bit accumulator: 2 x 1020
    @(negedge clk);
    b_cfg_valid  = 1;
    b_cfg_chunks = 2;
    lane_b       = 255;
    @(negedge clk);
    b_cfg_valid = 0;
    b_in_valid  = 1;
    repeat (2) @(negedge clk);
    b_in_valid = 0;
    wait_b("b_ovf_valid");
    chk("b_ovf_data", b_res_data, 1016);
    chk("b_ovf_flag", b_res_ovf, 1);
    b_res_ready = 1;
    @(negedge clk);
    b_res_ready = 0;

    // reset mid-FEED with beats still inside the tree
    b_cfg_valid  = 1;
    b_cfg_chunks = 5;
    @(negedge clk);
    b_cfg_valid = 0;
    b_in_valid  = 1;
    repeat (4) @(negedge clk);
    b_in_valid = 0;
    chk("b_pre_rst_in_ready", b_in_ready, 1);
    chk("b_pre_rst_ovf", b_res_ovf, 1);
    rst_n = 0;
    #1;
    chk("b_rst_in_ready", b_in_ready, 0);
    chk("b_rst_cfg_ready", b_cfg_ready, 1);
    chk("b_rst_busy", b_busy, 0);
    chk("b_rst_res_valid", b_res_valid, 0);
    chk("b_rst_res_data", b_res_data, 0);
    chk("b_rst_res_ovf", b_res_ovf, 0);
    #1;
    rst_n = 1;
    b_cfg_valid  = 1;
    b_cfg_chunks = 1;
    lane_b       = 1;
    @(negedge clk);
    b_cfg_valid = 0;
    b_in_valid  = 1;
    @(negedge clk);
    b_in_valid = 0;
    wait_b("b_post_valid");
    chk("b_post_data", b_res_data, 4);
    chk("b_post_ovf", b_res_ovf, 0);
    b_res_ready = 1;
    @(negedge clk);
    b_res_ready = 0;
    chk("b_post_clr", b_res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
